axi_burst_arbiter: RTL and testbench

AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

---
 rtl/axi_burst_arbiter.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_burst_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_arbiter.sv
// ---------------------------------------------------------------------------
// axi_burst_arbiter
//
// Two-master to one-slave AXI burst arbiter. The write path (AW/W/B) and the
// read path (AR/R) each have their own FSM and their own grant, so one master
// may own the write path while the other owns the read path.
//
// Each FSM spends one cycle in IDLE to register a one-hot winner. It then
// routes the granted master's channels straight through to the slave until
// the burst's terminating handshake:
//   write: B handshake
//   read : last R beat
// The non-granted master sees all of its outputs held at zero. Its held
// valids simply wait and are arbitrated the next time the FSM is idle.
//
// Arbitration:
//   default                        round-robin; with both requesting, the
//                                  master not served last wins; a single
//                                  requester always wins.
//   ARB_FIXED_PRIORITY_EN defined  master 0 always wins ties.
//
// Parameters:
//   ADDR_WIDTH  AXI address width (default 32)
//   DATA_WIDTH  AXI data width    (default 8)
//
// Ports:
//   clk, rstn                clock; synchronous active-low reset
//   m_aw*/m_w*/m_b*          master write channels, master i at [i*W +: W]
//   m_ar*/m_r*               master read channels, same packing
//   s_aw*/s_w*/s_b*          slave write channels (single, unpacked)
//   s_ar*/s_r*               slave read channels
//   wr_grant, rd_grant       one-hot current owner of each path, 0 when idle
// ---------------------------------------------------------------------------
module axi_burst_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master-side AW
  input  logic [2*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [7:0]              m_awlen,
  input  logic [5:0]              m_awsize,
  input  logic [3:0]              m_awburst,
  input  logic [1:0]              m_awvalid,
  output logic [1:0]              m_awready,
  // master-side W
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  input  logic [1:0]              m_wlast,
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,
  // master-side B
  output logic [3:0]              m_bresp,
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,
  // master-side AR
  input  logic [2*ADDR_WIDTH-1:0] m_araddr,
  input  logic [7:0]              m_arlen,
  input  logic [5:0]              m_arsize,
  input  logic [3:0]              m_arburst,
  input  logic [1:0]              m_arvalid,
  output logic [1:0]              m_arready,
  // master-side R
  output logic [2*DATA_WIDTH-1:0] m_rdata,
  output logic [3:0]              m_rresp,
  output logic [1:0]              m_rlast,
  output logic [1:0]              m_rvalid,
  input  logic [1:0]              m_rready,
  // slave-side AW
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic [3:0]              s_awlen,
  output logic [2:0]              s_awsize,
  output logic [1:0]              s_awburst,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  // slave-side W
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic                    s_wlast,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  // slave-side B
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  // slave-side AR
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic [3:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  // slave-side R
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  // ownership
  output logic [1:0]              wr_grant,
  output logic [1:0]              rd_grant
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;
  logic [1:0] wr_grant_reg, wr_grant_next;
  logic [1:0] rd_grant_reg, rd_grant_next;
  logic       wr_last_reg, wr_last_next;
  logic       rd_last_reg, rd_last_next;

  // Index of the current owner; only meaningful while the grant is non-zero.
  logic wr_idx, rd_idx;
  assign wr_idx = wr_grant_reg[1];
  assign rd_idx = rd_grant_reg[1];

  logic aw_phase, w_phase, b_phase, ar_phase, r_phase;

  // Unpacked per-master views of the packed inputs, so the slave-side
  // muxes are a plain array index by the owner.
  logic [ADDR_WIDTH-1:0] awaddr_m [0:1];
  logic [3:0]            awlen_m  [0:1];
  logic [2:0]            awsize_m [0:1];
  logic [1:0]            awburst_m[0:1];
  logic [DATA_WIDTH-1:0] wdata_m  [0:1];
  logic [ADDR_WIDTH-1:0] araddr_m [0:1];
  logic [3:0]            arlen_m  [0:1];
  logic [2:0]            arsize_m [0:1];
  logic [1:0]            arburst_m[0:1];

  // One-hot winner for a non-zero request vector.
  function automatic logic [1:0] pick(input logic [1:0] req, input logic last);
    logic [1:0] win;
`ifdef ARB_FIXED_PRIORITY_EN
    win = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    if (req == 2'b11)
      win = last ? 2'b01 : 2'b10;
    else
      win = req;
`endif
    return win;
  endfunction

  // ------------------------------------------------------------------ write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_reg <= W_IDLE;
      wr_grant_reg <= 2'b00;
      wr_last_reg  <= 1'b1;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_grant_reg <= wr_grant_next;
      wr_last_reg  <= wr_last_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_grant_next = wr_grant_reg;
    wr_last_next  = wr_last_reg;
    case (wr_state_reg)
      W_IDLE: begin
        if (|m_awvalid) begin
          wr_grant_next = pick(m_awvalid, wr_last_reg);
          wr_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        if (s_awvalid && s_awready)
          wr_state_next = W_DATA;
      end
      W_DATA: begin
        // Beats are not counted; only the flagged last beat ends the phase.
        if (s_wvalid && s_wready && s_wlast)
          wr_state_next = W_RESP;
      end
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          wr_state_next = W_IDLE;
          wr_grant_next = 2'b00;
          wr_last_next  = wr_idx;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_phase  = (wr_state_reg == W_ADDR);
    w_phase   = (wr_state_reg == W_DATA);
    b_phase   = (wr_state_reg == W_RESP);
    s_awaddr  = aw_phase ? awaddr_m[wr_idx]  : '0;
    s_awlen   = aw_phase ? awlen_m[wr_idx]   : '0;
    s_awsize  = aw_phase ? awsize_m[wr_idx]  : '0;
    s_awburst = aw_phase ? awburst_m[wr_idx] : '0;
    s_awvalid = aw_phase & m_awvalid[wr_idx];
    s_wdata   = w_phase ? wdata_m[wr_idx] : '0;
    s_wlast   = w_phase & m_wlast[wr_idx];
    s_wvalid  = w_phase & m_wvalid[wr_idx];
    s_bready  = b_phase & m_bready[wr_idx];
  end

  // ------------------------------------------------------------------- read
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state_reg <= R_IDLE;
      rd_grant_reg <= 2'b00;
      rd_last_reg  <= 1'b1;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_grant_reg <= rd_grant_next;
      rd_last_reg  <= rd_last_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_grant_next = rd_grant_reg;
    rd_last_next  = rd_last_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (|m_arvalid) begin
          rd_grant_next = pick(m_arvalid, rd_last_reg);
          rd_state_next = R_ADDR;
        end
      end
      R_ADDR: begin
        if (s_arvalid && s_arready)
          rd_state_next = R_DATA;
      end
      R_DATA: begin
        if (s_rvalid && s_rready && s_rlast) begin
          rd_state_next = R_IDLE;
          rd_grant_next = 2'b00;
          rd_last_next  = rd_idx;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_phase  = (rd_state_reg == R_ADDR);
    r_phase   = (rd_state_reg == R_DATA);
    s_araddr  = ar_phase ? araddr_m[rd_idx]  : '0;
    s_arlen   = ar_phase ? arlen_m[rd_idx]   : '0;
    s_arsize  = ar_phase ? arsize_m[rd_idx]  : '0;
    s_arburst = ar_phase ? arburst_m[rd_idx] : '0;
    s_arvalid = ar_phase & m_arvalid[rd_idx];
    s_rready  = r_phase & m_rready[rd_idx];
  end

  // ----------------------------------------------------- per-master routing
  // Everything returned to a master is gated by its own grant bit, so the
  // non-owner sees zeros on every ready, valid and data output.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic wr_own, rd_own;
      assign wr_own = wr_grant_reg[gi];
      assign rd_own = rd_grant_reg[gi];

      assign awaddr_m[gi]  = m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign awlen_m[gi]   = m_awlen[gi*4 +: 4];
      assign awsize_m[gi]  = m_awsize[gi*3 +: 3];
      assign awburst_m[gi] = m_awburst[gi*2 +: 2];
      assign wdata_m[gi]   = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign araddr_m[gi]  = m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign arlen_m[gi]   = m_arlen[gi*4 +: 4];
      assign arsize_m[gi]  = m_arsize[gi*3 +: 3];
      assign arburst_m[gi] = m_arburst[gi*2 +: 2];

      assign m_awready[gi] = aw_phase & wr_own & s_awready;
      assign m_wready[gi]  = w_phase & wr_own & s_wready;
      assign m_bvalid[gi]  = b_phase & wr_own & s_bvalid;
      assign m_bresp[gi*2 +: 2] = (b_phase & wr_own) ? s_bresp : 2'b00;

      assign m_arready[gi] = ar_phase & rd_own & s_arready;
      assign m_rvalid[gi]  = r_phase & rd_own & s_rvalid;
      assign m_rlast[gi]   = r_phase & rd_own & s_rlast;
      assign m_rresp[gi*2 +: 2] = (r_phase & rd_own) ? s_rresp : 2'b00;
      assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
        (r_phase & rd_own) ? s_rdata : '0;
    end
  endgenerate

  assign wr_grant = wr_grant_reg;
  assign rd_grant = rd_grant_reg;

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_arbiter
//
// Directed bench for axi_burst_arbiter. The bench plays both masters and the
// slave. Expected values are hand-derived constants. Honours
// ARB_FIXED_PRIORITY_EN for the arbitration expectations.
// ---------------------------------------------------------------------------
module tb_axi_burst_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [2*AW-1:0] m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic [5:0]    m_awsize, m_arsize;
  logic [3:0]    m_awburst, m_arburst;
  logic [1:0]    m_awvalid, m_awready, m_arvalid, m_arready;
  logic [2*DW-1:0] m_wdata, m_rdata;
  logic [1:0]    m_wlast, m_wvalid, m_wready;
  logic [3:0]    m_bresp, m_rresp;
  logic [1:0]    m_bvalid, m_bready, m_rlast, m_rvalid, m_rready;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [3:0]    s_awlen, s_arlen;
  logic [2:0]    s_awsize, s_arsize;
  logic [1:0]    s_awburst, s_arburst;
  logic          s_awvalid, s_awready, s_arvalid, s_arready;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          s_wlast, s_wvalid, s_wready;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
  logic [1:0]    wr_grant, rd_grant;

  axi_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] wd [0:15];

  // Returns 2 time units after a rising edge; inputs are driven there and
  // outputs are sampled 1 unit later, well clear of either edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the arbitration edge with master m expected to own
  // the write path; runs AW, nb W beats from wd[], and B with response resp.
  task automatic serve_write(input int m, input logic [31:0] addr, input int nb,
                             input logic [1:0] resp);
    logic [1:0] oh;
    oh = 2'b01 << m;
    #1;
    chk("wr_grant", wr_grant, oh);
    chk("s_awvalid", s_awvalid, 1);
    chk("s_awaddr", s_awaddr, addr);
    chk("m_awready", m_awready, oh);
    tick();
    m_awvalid[m] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      m_wdata[m*DW +: DW] = wd[b];
      m_wlast[m]  = (b == nb-1);
      m_wvalid[m] = 1'b1;
      #1;
      chk("s_wdata", s_wdata, wd[b]);
      chk("s_wlast", s_wlast, (b == nb-1));
      chk("m_wready", m_wready, oh);
      tick();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m]  = 1'b0;
    s_bvalid    = 1'b1;
    s_bresp     = resp;
    m_bready[m] = 1'b1;
    #1;
    chk("s_wvalid_in_resp", s_wvalid, 0);
    chk("m_bvalid", m_bvalid, oh);
    chk("m_bresp", m_bresp, {2'b00, resp} << (2*m));
    chk("s_bready", s_bready, 1);
    tick();
    s_bvalid    = 1'b0;
    s_bresp     = 2'b00;
    m_bready[m] = 1'b0;
    #1;
    chk("wr_grant_after_b", wr_grant, 0);
    chk("s_awvalid_idle", s_awvalid, 0);
  endtask

  initial begin
    int beat;
    int cyc;
    int first2;
    logic [31:0] addr2;

    rstn = 1'b0;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
    m_wdata = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = '0;
    m_rready = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bresp = '0; s_bvalid = 1'b0;
    s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    for (int i = 0; i < 16; i++) wd[i] = 8'h00;

    // ---- reset state
    repeat (2) tick();
    #1;
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_m_awready", m_awready, 0);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_bready", s_bready, 0);
    chk("rst_s_rready", s_rready, 0);
    rstn = 1'b1;

    // ---- single m0 write, addr 0x10, len 3, INCR
    wd[0] = 8'h05; wd[1] = 8'h03; wd[2] = 8'h00; wd[3] = 8'hA5;
    m_awaddr[31:0] = 32'h10; m_awlen[3:0] = 4'd3; m_awburst[1:0] = 2'b01;
    m_awvalid[0] = 1'b1;
    #1;
    chk("arb_cycle_s_awvalid", s_awvalid, 0);
    tick();
    #1;
    chk("w1_s_awlen", s_awlen, 3);
    chk("w1_s_awburst", s_awburst, 1);
    serve_write(0, 32'h10, 4, 2'b00);

    // ---- simultaneous AW pairs after a fresh reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_awaddr = {32'h200, 32'h100}; m_awlen = 8'h11; m_awvalid = 2'b11;
    wd[0] = 8'h11; wd[1] = 8'h22;
    #1;
    chk("pair_idle_s_awvalid", s_awvalid, 0);
    tick();
    serve_write(0, 32'h100, 2, 2'b00);
    m_awaddr[31:0] = 32'h300;
    m_awvalid[0] = 1'b1;
    tick();
    first2 = FIXED ? 0 : 1;
    addr2  = FIXED ? 32'h300 : 32'h200;
    serve_write(first2, addr2, 2, first2 ? 2'b10 : 2'b00);
    tick();
    serve_write(1 - first2, FIXED ? 32'h200 : 32'h300, 2, FIXED ? 2'b10 : 2'b00);

    // ---- concurrent m0 write and m1 read of 0x10
    m_awaddr[31:0] = 32'h40; m_awlen[3:0] = 4'd3; m_awvalid[0] = 1'b1;
    m_araddr[63:32] = 32'h10; m_arlen[7:4] = 4'd3; m_arburst[3:2] = 2'b01;
    m_arvalid[1] = 1'b1;
    tick();
    #1;
    chk("cc_wr_grant", wr_grant, 2'b01);
    chk("cc_rd_grant", rd_grant, 2'b10);
    chk("cc_s_awaddr", s_awaddr, 32'h40);
    chk("cc_s_araddr", s_araddr, 32'h10);
    chk("cc_s_arlen", s_arlen, 3);
    chk("cc_m_awready", m_awready, 2'b01);
    chk("cc_m_arready", m_arready, 2'b10);
    tick();
    m_awvalid[0] = 1'b0;
    m_arvalid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_wdata[7:0] = 8'(8'h60 + k); m_wvalid[0] = 1'b1; m_wlast[0] = (k == 3);
      s_rdata = 8'(8'h90 + k); s_rlast = (k == 3); s_rvalid = 1'b1;
      m_rready[1] = 1'b1;
      m_awvalid[1] = (k == 1);   // short pulse while busy: must be dropped
      #1;
      chk("cc_overlap_wr", wr_grant, 2'b01);
      chk("cc_overlap_rd", rd_grant, 2'b10);
      chk("cc_s_wdata", s_wdata, 8'(8'h60 + k));
      chk("cc_m_wready", m_wready, 2'b01);
      chk("cc_m_rdata", m_rdata, {8'(8'h90 + k), 8'h00});
      chk("cc_m_rvalid", m_rvalid, 2'b10);
      chk("cc_m_rlast", m_rlast, (k == 3) ? 2'b10 : 2'b00);
      chk("cc_m_awready_nongrant", m_awready, 2'b00);
      tick();
    end
    m_wvalid = '0; m_wlast = '0; m_awvalid = '0;
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("cc_rd_done", rd_grant, 0);
    chk("cc_wr_in_resp", wr_grant, 2'b01);
    s_bvalid = 1'b1; m_bready[0] = 1'b1;
    #1;
    chk("cc_m_bvalid", m_bvalid, 2'b01);
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    tick();
    #1;
    chk("dropped_valid_no_grant", wr_grant, 0);
    chk("dropped_valid_no_aw", s_awvalid, 0);

    // ---- m1 16-beat read with toggling rready, m0 AR held meanwhile
    m_araddr[63:32] = 32'h500; m_arlen[7:4] = 4'd15; m_arvalid[1] = 1'b1;
    tick();
    m_araddr[31:0] = 32'h700; m_arlen[3:0] = 4'd0; m_arvalid[0] = 1'b1;
    #1;
    chk("lr_rd_grant", rd_grant, 2'b10);
    chk("lr_s_arlen", s_arlen, 15);
    chk("lr_s_araddr", s_araddr, 32'h500);
    chk("lr_m_arready", m_arready, 2'b10);
    tick();
    m_arvalid[1] = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 64) begin
      m_rready[1] = (cyc % 2 == 0);
      s_rdata  = 8'(8'hA0 + beat);
      s_rlast  = (beat == 15);
      s_rvalid = 1'b1;
      #1;
      chk("lr_m_rdata", m_rdata, {8'(8'hA0 + beat), 8'h00});
      chk("lr_m_rlast", m_rlast, (beat == 15) ? 2'b10 : 2'b00);
      chk("lr_m_arready_held", m_arready, 2'b00);
      chk("lr_s_rready", s_rready, (cyc % 2 == 0));
      if (m_rready[1]) beat++;
      cyc++;
      tick();
    end
    chk("lr_beats", beat, 16);
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("lr_rd_idle", rd_grant, 0);
    tick();
    #1;
    chk("held_ar_grant", rd_grant, 2'b01);
    chk("held_ar_addr", s_araddr, 32'h700);
    tick();
    m_arvalid[0] = 1'b0;
    s_rdata = 8'h33; s_rlast = 1'b1; s_rvalid = 1'b1; m_rready[0] = 1'b1;
    #1;
    chk("held_m_rdata", m_rdata, 16'h0033);
    chk("held_m_rvalid", m_rvalid, 2'b01);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    #1;
    chk("held_rd_done", rd_grant, 0);

    // ---- reset mid-burst, then m1 write
    m_awaddr[31:0] = 32'h80; m_awlen[3:0] = 4'd3; m_awvalid[0] = 1'b1;
    tick();
    #1;
    chk("mr_wr_grant", wr_grant, 2'b01);
    tick();
    m_awvalid[0] = 1'b0;
    m_wdata[7:0] = 8'h01; m_wvalid[0] = 1'b1;
    tick();
    m_wdata[7:0] = 8'h02;
    rstn = 1'b0; s_bvalid = 1'b1; s_rvalid = 1'b1; s_rdata = 8'h77;
    tick();
    #1;
    chk("mr_wr_grant_rst", wr_grant, 0);
    chk("mr_rd_grant_rst", rd_grant, 0);
    chk("mr_s_wvalid", s_wvalid, 0);
    chk("mr_s_wdata", s_wdata, 0);
    chk("mr_m_wready", m_wready, 0);
    chk("mr_m_bvalid", m_bvalid, 0);
    chk("mr_m_rvalid", m_rvalid, 0);
    chk("mr_m_rdata", m_rdata, 0);
    rstn = 1'b1; s_bvalid = 1'b0; s_rvalid = 1'b0; s_rdata = 8'h00;
    m_wvalid = '0; m_wdata = '0;
    m_awaddr[63:32] = 32'h90; m_awlen[7:4] = 4'd1; m_awvalid[1] = 1'b1;
    wd[0] = 8'h5A; wd[1] = 8'h5B;
    tick();
    serve_write(1, 32'h90, 2, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
